add_nibble_sched: RTL and testbench
===================================

# add_nibble_sched

Multi-cycle 16-bit adder scheduler that shares a single 4-bit generate/propagate carry-lookahead slice between two requesters. It arbitrates round-robin and latches the granted requester's operands. It then steps the slice over four nibbles, least significant first, carrying between nibbles in a register, and returns a registered sum with a one-cycle done pulse. It sits beside the execute stage as the shared arithmetic resource for low-rate multi-cycle users, such as the address/offset unit and the debug/test port.

## Interface
Parameters: none (width fixed at 16 bits = 4 nibbles).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  2  req[i] high = requester i wants an add; level, sampled only in IDLE
- a0, b0  in  16  requester 0 operands; stable while req[0] high and until gnt[0]
- a1, b1  in  16  requester 1 operands; same rule
- cin0, cin1  in  1  carry-in per requester
- sub0, sub1  in  1  subtract select; present only with ADD_SCHED_SUB_EN
- gnt  out  2  one-hot, one-cycle pulse: operands of requester i captured
- busy  out  1  high in BUSY and DONE states
- done  out  1  one-cycle pulse: result valid
- done_id  out  1  requester owning the result; held until next grant
- sum  out  16  result; held until next grant
- cout  out  1  carry out of bit 15
- ovf  out  1  signed overflow: carry into bit 15 XOR cout

## Operation
- States: IDLE, BUSY, DONE; plus 2-bit nibble counter nib, carry register c, 1-bit owner, 1-bit last-served pointer lst.
- IDLE, req != 0: grant winner. Capture A, B, cin and owner. Set c = cin, nib = 0, clear sum. Go to BUSY.
- Arbitration:
  - Single requester wins outright.
  - Both requesting: winner = !lst. lst updates to the winner at grant.
- BUSY, each cycle, on nibble nib:
  - g[k] = a&b and p[k] = a|b per bit.
  - Lookahead carries:
    - c1 = g0|p0c
    - c2 = g1|p1g0|p1p0c
    - c3 = g2|p2g1|p2p1g0|p2p1p0c
    - c4 = g3|p3c3 (expanded form)
  - sum bits = a^b^carry-in-of-bit.
  - sum[4nib+3:4nib] ← nibble result, c ← c4, nib++.
  - At nib == 3: also cout ← c4 and ovf ← c3^c4. Go to DONE.
- DONE: done = 1 for exactly one cycle. Go to IDLE. No grant is issued from DONE.
- Requests arriving in BUSY/DONE wait. A req still high after done is a new request, arbitrated normally in IDLE.
- Operand changes after the gnt cycle have no effect.

## Timing
- Reset values:
  - state IDLE, nib 0, c 0, lst 1 (requester 0 favoured first)
  - gnt 0, busy 0, done 0, done_id 0, sum 0, cout 0, ovf 0
- Latency: req seen in IDLE cycle N → gnt high cycle N+1 → done high cycle N+5 with sum/cout/ovf valid.
- Throughput: one add per 6 cycles under continuous request. Next gnt is at the earliest N+7.
- rst mid-operation: immediate abort, no done, outputs to reset values, lst back to 1.
- Simultaneous req rise on both: one gnt only. The other requester is granted after the first's DONE.
- Carry wrap: all-ones + 1 gives sum 0, cout 1.

## Configuration
- ADD_SCHED_SUB_EN defined:
  - Ports sub0/sub1 exist.
  - With captured sub = 1, B is captured as ~B and c starts at 1; cin is ignored.
  - ovf reflects signed A−B overflow.
- ADD_SCHED_SUB_EN undefined:
  - sub0/sub1 are absent.
  - Add only; B and cin are used as supplied.

## Test plan
- Reset, then req=01, a0=0x1234, b0=0x0FCD, cin0=0. Required:
  - gnt=01 one cycle later
  - done 5 cycles after req with sum=0x2201, cout=0, ovf=0, done_id=0
- req=10, a1=0xFFFF, b1=0x0000, cin1=1 → sum=0x0000, cout=1, ovf=0, done_id=1.
- req=11 from reset. Required:
  - gnt=01 first
  - held req=11 gives gnt=10 at the next IDLE
  - alternation continues
- a0=0x7FFF, b0=0x0001 → sum=0x8000, ovf=1, cout=0.
- Assert rst two cycles after gnt. Required:
  - no done pulse
  - all outputs 0
  - next req=11 grants requester 0
- With ADD_SCHED_SUB_EN: sub0=1, a0=0x0005, b0=0x0007 → sum=0xFFFE, cout=0, ovf=0.

Source files
------------

// File: rtl/add_nibble_sched.sv
// -----------------------------------------------------------------------------
// add_nibble_sched
//
// Purpose:
//   Multi-cycle 16-bit adder shared between two requesters. A single 4-bit
//   generate/propagate carry-lookahead slice is stepped over the four nibbles
//   of the granted operands, least significant nibble first. The carry between
//   nibbles is kept in a register. The result is returned with a one-cycle
//   done pulse.
//
//   Arbitration is round-robin. When both requesters ask in the same IDLE
//   cycle, the one that was not served last wins. After reset the last-served
//   pointer is 1, so requester 0 is favoured first.
//
// Optional feature:
//   ADD_SCHED_SUB_EN - when defined, the ports sub0/sub1 exist. A captured
//   sub=1 turns the add into A - B: B is captured inverted, the carry starts
//   at 1, and cin is ignored. When the macro is undefined, the block only
//   adds and sub0/sub1 are absent.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   req        in   2   request level per requester, sampled in IDLE only
//   a0, b0     in  16   requester 0 operands
//   a1, b1     in  16   requester 1 operands
//   cin0/cin1  in   1   carry-in per requester
//   sub0/sub1  in   1   subtract select (ADD_SCHED_SUB_EN only)
//   gnt        out  2   one-hot, one-cycle pulse: operands captured
//   busy       out  1   high in BUSY and DONE
//   done       out  1   one-cycle pulse: sum/cout/ovf valid
//   done_id    out  1   owner of the current/last result
//   sum        out 16   result
//   cout       out  1   carry out of bit 15
//   ovf        out  1   signed overflow (carry into bit 15 XOR cout)
// -----------------------------------------------------------------------------
module add_nibble_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  input  logic        cin0,
  input  logic        cin1,
`ifdef ADD_SCHED_SUB_EN
  input  logic        sub0,
  input  logic        sub1,
`endif
  output logic [1:0]  gnt,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [15:0] sum,
  output logic        cout,
  output logic        ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t      state_q;
  logic [1:0]  nib_q;      // nibble currently being processed
  logic        c_q;        // carry into the current nibble
  logic        owner_q;    // requester that owns the operation in flight
  logic        lst_q;      // last requester served
  logic [15:0] a_q;
  logic [15:0] b_q;        // already inverted for subtraction
  logic [15:0] sum_q;
  logic        cout_q;
  logic        ovf_q;
  logic [1:0]  gnt_q;
  logic        busy_q;
  logic        done_q;

  // ---------------------------------------------------------------------------
  // Arbitration and operand selection (evaluated in IDLE)
  // ---------------------------------------------------------------------------
  logic        win_d;      // winning requester index
  logic [15:0] op_a_d;
  logic [15:0] op_b_d;
  logic        c_init_d;   // carry into nibble 0

  always_comb begin
    win_d = 1'b0;
    if (req == 2'b11) begin
      // Contention: hand the slice to whoever was not served last.
      win_d = ~lst_q;
    end else if (req[1]) begin
      win_d = 1'b1;
    end else begin
      win_d = 1'b0;
    end
  end

  logic [15:0] b_raw_d;
  logic        cin_raw_d;

  assign op_a_d    = win_d ? a1   : a0;
  assign b_raw_d   = win_d ? b1   : b0;
  assign cin_raw_d = win_d ? cin1 : cin0;

`ifdef ADD_SCHED_SUB_EN
  logic sub_sel_d;

  assign sub_sel_d = win_d ? sub1 : sub0;

  // A - B is computed as A + ~B + 1. The requester's cin plays no part here.
  assign op_b_d   = sub_sel_d ? ~b_raw_d : b_raw_d;
  assign c_init_d = sub_sel_d ? 1'b1     : cin_raw_d;
`else
  assign op_b_d   = b_raw_d;
  assign c_init_d = cin_raw_d;
`endif

  // ---------------------------------------------------------------------------
  // Shared 4-bit carry-lookahead slice
  // ---------------------------------------------------------------------------
  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] g;           // generate
  logic [3:0] p;           // propagate
  logic [3:0] x;           // half-sum
  logic [3:0] cc;          // carry into each bit of the slice
  logic [3:0] nib_sum;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;

  assign nib_a = a_q[{nib_q, 2'b00} +: 4];
  assign nib_b = b_q[{nib_q, 2'b00} +: 4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      assign g[gi]       = nib_a[gi] & nib_b[gi];
      assign p[gi]       = nib_a[gi] | nib_b[gi];
      assign x[gi]       = nib_a[gi] ^ nib_b[gi];
      assign nib_sum[gi] = x[gi] ^ cc[gi];
    end
  endgenerate

  // All carries are flat sum-of-products terms in g, p and the nibble
  // carry-in. None of them ripples through the carry of a previous bit.
  assign c1 = g[0]
            | (p[0] & c_q);
  assign c2 = g[1]
            | (p[1] & g[0])
            | (p[1] & p[0] & c_q);
  assign c3 = g[2]
            | (p[2] & g[1])
            | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & c_q);
  assign c4 = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c_q);

  assign cc = {c3, c2, c1, c_q};

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      nib_q   <= 2'd0;
      c_q     <= 1'b0;
      owner_q <= 1'b0;
      lst_q   <= 1'b1;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      sum_q   <= 16'd0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // gnt and done are single-cycle pulses unless re-asserted below.
      gnt_q  <= 2'b00;
      done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (req != 2'b00) begin
            gnt_q   <= win_d ? 2'b10 : 2'b01;
            owner_q <= win_d;
            lst_q   <= win_d;
            a_q     <= op_a_d;
            b_q     <= op_b_d;
            c_q     <= c_init_d;
            nib_q   <= 2'd0;
            sum_q   <= 16'd0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_BUSY;
          end
        end

        S_BUSY: begin
          sum_q[{nib_q, 2'b00} +: 4] <= nib_sum;
          c_q                        <= c4;
          nib_q                      <= nib_q + 2'd1;
          if (nib_q == 2'd3) begin
            // In the top nibble, c3 is the carry into bit 15.
            cout_q  <= c4;
            ovf_q   <= c3 ^ c4;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          // No grant here: pending requests are seen in the following IDLE.
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = owner_q;   // captured at grant, held until the next grant
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_add_nibble_sched.sv
module tb_add_nibble_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] a0, b0, a1, b1;
  logic        cin0, cin1;
  logic        sub0, sub1;
  logic [1:0]  gnt;
  logic        busy, done, done_id, cout, ovf;
  logic [15:0] sum;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic lst_m;        // round-robin pointer: last requester served

  add_nibble_sched dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .a0      (a0),
    .b0      (b0),
    .a1      (a1),
    .b1      (b1),
    .cin0    (cin0),
    .cin1    (cin1),
`ifdef ADD_SCHED_SUB_EN
    .sub0    (sub0),
    .sub1    (sub1),
`endif
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .sum     (sum),
    .cout    (cout),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 17-bit arithmetic. Returns {ovf, cout, sum[15:0]}.
  function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
    logic [15:0] bb;
    logic        ci;
    logic [16:0] full;
    logic        v;
    bb   = b;
    ci   = cin;
`ifdef ADD_SCHED_SUB_EN
    if (sub) begin
      bb = ~b;
      ci = 1'b1;
    end
`else
    if (sub) ci = cin;
`endif
    full = {1'b0, a} + {1'b0, bb} + {16'd0, ci};
    v    = (a[15] == bb[15]) && (full[15] != a[15]);
    return {v, full};
  endfunction

  task automatic chk_outs_zero(input string pfx);
    chk({pfx, "_gnt"},     32'(gnt),     0);
    chk({pfx, "_busy"},    32'(busy),    0);
    chk({pfx, "_done"},    32'(done),    0);
    chk({pfx, "_done_id"}, 32'(done_id), 0);
    chk({pfx, "_sum"},     32'(sum),     0);
    chk({pfx, "_cout"},    32'(cout),    0);
    chk({pfx, "_ovf"},     32'(ovf),     0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_outs_zero("rst");
    rst   = 1'b0;
    lst_m = 1'b1;
  endtask

  // Called at a negedge while the DUT is idle. Drives req and then follows
  // the whole transaction to one cycle past done.
  task automatic run_txn(input logic [1:0] r, input bit hold);
    int          n;
    logic        w;
    logic [17:0] e;
    req = r;
    n   = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 2'b00 && n < 20);
    if (gnt == 2'b00) begin
      chk("gnt_timeout", 0, 1);
      return;
    end
    w     = (r == 2'b11) ? ~lst_m : r[1];
    lst_m = w;
    chk("gnt",         32'(gnt),  w ? 2 : 1);
    chk("gnt_lat",     32'(n),    1);
    chk("busy_at_gnt", 32'(busy), 1);
    e = w ? ref_add(a1, b1, cin1, sub1) : ref_add(a0, b0, cin0, sub0);
    if (!hold) req[w] = 1'b0;
    // Operands of the winner may change freely once the grant is seen.
    if (w) begin
      a1 = 16'($urandom); b1 = 16'($urandom); cin1 = 1'($urandom);
    end else begin
      a0 = 16'($urandom); b0 = 16'($urandom); cin0 = 1'($urandom);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 10);
    if (!done) begin
      chk("done_timeout", 0, 1);
      return;
    end
    chk("done_lat",  32'(n),       4);
    chk("sum",       32'(sum),     32'(e[15:0]));
    chk("cout",      32'(cout),    32'(e[16]));
    chk("ovf",       32'(ovf),     32'(e[17]));
    chk("done_id",   32'(done_id), 32'(w));
    chk("busy_done", 32'(busy),    1);
    $display("txn req=%b owner=%0d sum=%h cout=%b ovf=%b (exp %h %b %b)",
             r, w, sum, cout, ovf, e[15:0], e[16], e[17]);
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("busy_after", 32'(busy), 0);
  endtask

  function automatic logic [15:0] pick_operand();
    logic [15:0] v;
    case ($urandom_range(0, 5))
      0:       v = 16'hFFFF;
      1:       v = 16'h7FFF;
      2:       v = 16'h8000;
      3:       v = 16'h0000;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    int seen;
    rst = 1'b1; req = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    cin0 = 1'b0; cin1 = 1'b0; sub0 = 1'b0; sub1 = 1'b0;
    lst_m = 1'b1;
    @(negedge clk);
    do_reset();

    // Directed: basic add on requester 0, then carry wrap on requester 1.
    a0 = 16'h1234; b0 = 16'h0FCD; cin0 = 1'b0;
    run_txn(2'b01, 1'b0);
    a1 = 16'hFFFF; b1 = 16'h0000; cin1 = 1'b1;
    run_txn(2'b10, 1'b0);

    // Held contention from reset: alternation 0,1,0,1.
    do_reset();
    a0 = 16'h0102; b0 = 16'h0304; cin0 = 1'b0;
    a1 = 16'hA0A0; b1 = 16'h0B0B; cin1 = 1'b1;
    repeat (4) run_txn(2'b11, 1'b1);
    req = 2'b00;

    // Signed overflow boundary.
    a0 = 16'h7FFF; b0 = 16'h0001; cin0 = 1'b0;
    run_txn(2'b01, 1'b0);

    // Reset two cycles after a grant: abort, no done, pointer back to 1.
    a0 = 16'h1111; b0 = 16'h2222;
    req = 2'b01;
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 1);
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_outs_zero("abort");
    lst_m = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", 32'(seen), 0);
    a0 = 16'h4000; b0 = 16'h4000; a1 = 16'h0001; b1 = 16'h0002;
    run_txn(2'b11, 1'b0);

`ifdef ADD_SCHED_SUB_EN
    sub0 = 1'b1; a0 = 16'h0005; b0 = 16'h0007; cin0 = 1'b0;
    run_txn(2'b01, 1'b0);
    sub0 = 1'b0;
`endif

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      a0 = pick_operand(); b0 = pick_operand();
      a1 = pick_operand(); b1 = pick_operand();
      cin0 = 1'($urandom); cin1 = 1'($urandom);
`ifdef ADD_SCHED_SUB_EN
      sub0 = 1'($urandom); sub1 = 1'($urandom);
`endif
      run_txn(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        req = 2'b00;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
